// File: rtl/strike_pkg.sv
// strike_pkg: shared constants, event bundle type and width helper
// for the strike event scheduler.
package strike_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int ZONE_W_DEF = 3;
  localparam int CHAN_W_DEF = $clog2(N_CH_DEF);

  typedef struct packed {
    logic [CHAN_W_DEF-1:0] chan;
    logic [ZONE_W_DEF-1:0] zone;
  } strike_evt_t;

  // channel index width, never below one bit
  function automatic int chan_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over N requesters, searching upward
// from the pointer; the pointer moves past the winner when advanced.
module rr_arbiter
  import strike_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = chan_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  logic [IW-1:0] ptr;
  logic [IW:0]   s;
  logic [IW-1:0] j;

  // first requester at or after ptr, wrapping at N-1 -> 0
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    s       = '0;
    j       = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      if (s >= (IW+1)'(N))
        s = s - (IW+1)'(N);
      j = s[IW-1:0];
      if (!any_gnt && req[j]) begin
        any_gnt = 1'b1;
        gnt_idx = j;
        gnt[j]  = 1'b1;
      end
    end
  end

  // pointer moves to the channel after the one just granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (advance && any_gnt)
      ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/strike_event_scheduler.sv
// strike_event_scheduler: one pending event per channel, refractory
// window per channel, round-robin drain onto a valid/ready port.
module strike_event_scheduler
  import strike_pkg::*;
#(
  parameter int N_CH           = N_CH_DEF,
  parameter int ZONE_W         = ZONE_W_DEF,
  parameter int REFRACT_CYCLES = 1000,
  parameter int REFRACT_W      = 16,
  parameter int DROP_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_CH-1:0]          strike_in,
  input  logic [N_CH*ZONE_W-1:0]   zone_in,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_CH)-1:0]  evt_chan,
  output logic [ZONE_W-1:0]        evt_zone,
  output logic [N_CH-1:0]          pending,
  output logic [DROP_W-1:0]        drop_count,
  input  logic                     clear_drops
);

  localparam int CW     = chan_w(N_CH);
  localparam int NDW    = $clog2(N_CH+1);
  localparam int SUM_W  = DROP_W + NDW + 1;
  // the capture cycle itself is the first refractory cycle
  localparam int R_LOAD =
    (REFRACT_CYCLES > 0) ? REFRACT_CYCLES - 1 : 0;

  logic [N_CH-1:0]                pend_q;
  logic [N_CH-1:0][ZONE_W-1:0]    zone_q;
  logic [N_CH-1:0][REFRACT_W-1:0] refr_q;

  logic [N_CH-1:0] refr_free;
  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] take;
  logic [N_CH-1:0] cap;
  logic [N_CH-1:0] drop;
  logic [N_CH-1:0] gnt;
  logic [CW-1:0]   gnt_idx;
  logic            any_gnt;
  logic            loadable;
  logic [NDW-1:0]  n_drop;
  logic [SUM_W-1:0] drop_sum;

  assign loadable = !evt_valid || evt_ready;
  assign pending  = pend_q;

  rr_arbiter #(
    .N  (N_CH),
    .IW (CW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pend_q),
    .advance (loadable),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // classify each strike as capture, drop or ignore
  always_comb begin
    n_drop = '0;
    for (int k = 0; k < N_CH; k++) begin
      refr_free[k] = (refr_q[k] == '0);
      hit[k]  = strike_in[k] && enable && refr_free[k];
      take[k] = gnt[k] && loadable;
      cap[k]  = hit[k] && (!pend_q[k] || take[k]);
      drop[k] = hit[k] && !cap[k];
      n_drop  = n_drop + NDW'(drop[k]);
    end
    drop_sum = SUM_W'(drop_count) + SUM_W'(n_drop);
  end

  // pending flags, latched zones and refractory counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      zone_q <= '0;
      refr_q <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        pend_q[k] <= cap[k] || (pend_q[k] && !take[k]);
        if (cap[k]) begin
          zone_q[k] <= zone_in[k*ZONE_W +: ZONE_W];
          refr_q[k] <= REFRACT_W'(R_LOAD);
        end else if (!refr_free[k]) begin
          refr_q[k] <= refr_q[k] - 1'b1;
        end
      end
    end
  end

  // output event register, reloaded whenever the slot frees up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_zone  <= '0;
    end else if (loadable) begin
      if (any_gnt) begin
        evt_valid <= 1'b1;
        evt_chan  <= gnt_idx;
        evt_zone  <= zone_q[gnt_idx];
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

  // saturating drop counter, clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_count <= '0;
    else if (clear_drops)
      drop_count <= '0;
    else if (drop_sum > SUM_W'({DROP_W{1'b1}}))
      drop_count <= '1;
    else
      drop_count <= drop_sum[DROP_W-1:0];
  end

endmodule

// File: tb/tb_strike_event_scheduler.sv
// tb_strike_event_scheduler: two instances (refractory 10 and 0) driven
// in lockstep and compared against an event-level reference model.
module tb_strike_event_scheduler;
  import strike_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [3:0]  strike;
  logic [11:0] zone_in;
  logic        ready;
  logic        clr;

  logic [1:0]       ov;
  logic [1:0][1:0]  och;
  logic [1:0][2:0]  ozn;
  logic [1:0][3:0]  opend;
  logic [1:0][7:0]  odrop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  strike_event_scheduler #(
    .N_CH(4), .ZONE_W(3), .REFRACT_CYCLES(10),
    .REFRACT_W(16), .DROP_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .strike_in(strike), .zone_in(zone_in),
    .evt_valid(ov[0]), .evt_ready(ready),
    .evt_chan(och[0]), .evt_zone(ozn[0]),
    .pending(opend[0]), .drop_count(odrop[0]),
    .clear_drops(clr)
  );

  strike_event_scheduler #(
    .N_CH(4), .ZONE_W(3), .REFRACT_CYCLES(0),
    .REFRACT_W(16), .DROP_W(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .strike_in(strike), .zone_in(zone_in),
    .evt_valid(ov[1]), .evt_ready(ready),
    .evt_chan(och[1]), .evt_zone(ozn[1]),
    .pending(opend[1]), .drop_count(odrop[1]),
    .clear_drops(clr)
  );

  // reference model: index 0 -> refractory 10, index 1 -> none
  int         rc[2] = '{10, 0};
  int         cyc;
  int         m_v[2];
  int         m_ch[2];
  int         m_zn[2];
  int         m_ptr[2];
  int         m_drop[2];
  logic [3:0] m_pend[2];
  int         m_pz[2][4];
  int         m_last[2][4];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 0; m_ch[d] = 0; m_zn[d] = 0;
      m_ptr[d] = 0; m_drop[d] = 0; m_pend[d] = '0;
      for (int k = 0; k < 4; k++) begin
        m_pz[d][k] = 0;
        m_last[d][k] = -100000;
      end
    end
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      bit   load;
      int   g;
      int   nd;
      logic [3:0] capm;
      load = (m_v[d] == 0) || ready;
      g = -1;
      nd = 0;
      capm = '0;
      if (load)
        for (int i = 0; i < 4; i++) begin
          int j;
          j = (m_ptr[d] + i) % 4;
          if (g < 0 && m_pend[d][j]) g = j;
        end
      for (int k = 0; k < 4; k++)
        if (strike[k] && enable && (cyc - m_last[d][k] >= rc[d])) begin
          if (!m_pend[d][k] || g == k) capm[k] = 1'b1;
          else nd++;
        end
      if (g >= 0) begin
        m_v[d] = 1; m_ch[d] = g; m_zn[d] = m_pz[d][g];
        m_pend[d][g] = 1'b0;
        m_ptr[d] = (g + 1) % 4;
      end else if (load) begin
        m_v[d] = 0;
      end
      for (int k = 0; k < 4; k++)
        if (capm[k]) begin
          m_pend[d][k] = 1'b1;
          m_pz[d][k] = int'(zone_in[k*3 +: 3]);
          m_last[d][k] = cyc;
        end
      if (clr) m_drop[d] = 0;
      else if (m_drop[d] + nd > 255) m_drop[d] = 255;
      else m_drop[d] = m_drop[d] + nd;
    end
    cyc++;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; strike = '0; zone_in = '0;
    enable = 1'b1; ready = 1'b1; clr = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; strike = '0; zone_in = '0;
    enable = 1'b1; ready = 1'b1; clr = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ov[d], och[d], ozn[d], opend[d], odrop[d]} !== '0) begin
        errors++;
        $display("FAIL reset d%0d got v%b c%0d z%0d p%b dr%0d req all 0",
                 d, ov[d], och[d], ozn[d], opend[d], odrop[d]);
      end
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    strike = 4'b0001; zone_in = 12'd5;
    tick();
    strike = '0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (opend[d] !== 4'b0001 || ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL single_t1 d%0d got p%b v%b req p0001 v0",
                 d, opend[d], ov[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== 1'b1 || och[d] !== 2'd0 || ozn[d] !== 3'd5) begin
        errors++;
        $display("FAIL single_t2 d%0d got v%b c%0d z%0d req v1 c0 z5",
                 d, ov[d], och[d], ozn[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL single_t3 d%0d got v%b req v0", d, ov[d]);
      end
    end
  endtask

  task automatic test_all_four();
    strike_evt_t exp_q[$];
    strike_evt_t e;
    do_reset();
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{chan: 2'(i), zone: 3'(i + 1)});
    exp_q.push_back('{chan: 2'd0, zone: 3'd6});
    exp_q.push_back('{chan: 2'd3, zone: 3'd7});
    strike = 4'b1111;
    zone_in = {3'd4, 3'd3, 3'd2, 3'd1};
    tick();
    strike = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ov[d] !== 1'b1 || och[d] !== e.chan || ozn[d] !== e.zone) begin
          errors++;
          $display("FAIL rr_burst d%0d #%0d got v%b c%0d z%0d req c%0d z%0d",
                   d, i, ov[d], och[d], ozn[d], e.chan, e.zone);
        end
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle d%0d got v%b req v0", d, ov[d]);
      end
    end
    repeat (12) tick();
    strike = 4'b1001;
    zone_in = {3'd7, 3'd0, 3'd0, 3'd6};
    tick();
    strike = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ov[d] !== 1'b1 || och[d] !== e.chan || ozn[d] !== e.zone) begin
          errors++;
          $display("FAIL rr_ptr d%0d #%0d got v%b c%0d z%0d req c%0d z%0d",
                   d, i, ov[d], och[d], ozn[d], e.chan, e.zone);
        end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    strike = 4'b0100;
    zone_in = 12'(6) << 6;
    tick();
    strike = '0;
    zone_in = '0;
    tick();
    for (int c = 0; c < 21; c++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ov[d] !== 1'b1 || och[d] !== 2'd2 || ozn[d] !== 3'd6) begin
          errors++;
          $display("FAIL hold d%0d cyc%0d got v%b c%0d z%0d req v1 c2 z6",
                   d, c, ov[d], och[d], ozn[d]);
        end
      end
      if (c < 20) tick();
    end
    ready = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL hold_xfer d%0d got v%b req v0", d, ov[d]);
      end
    end
  endtask

  task automatic test_drops();
    do_reset();
    ready = 1'b0;
    strike = 4'b0010;
    zone_in = 12'(3) << 3;
    repeat (3) tick();
    checks++;
    if (odrop[1] !== 8'd1 || odrop[0] !== 8'd0) begin
      errors++;
      $display("FAIL drop_first got r0:%0d r10:%0d req r0:1 r10:0",
               odrop[1], odrop[0]);
    end
    checks++;
    if (opend[1] !== 4'b0010 || ov[1] !== 1'b1 || och[1] !== 2'd1) begin
      errors++;
      $display("FAIL drop_state got p%b v%b c%0d req p0010 v1 c1",
               opend[1], ov[1], och[1]);
    end
    repeat (300) tick();
    checks++;
    if (odrop[1] !== 8'd255) begin
      errors++;
      $display("FAIL drop_sat got %0d req 255", odrop[1]);
    end
    checks++;
    if (odrop[0] !== 8'(m_drop[0])) begin
      errors++;
      $display("FAIL drop_refr got %0d req %0d", odrop[0], m_drop[0]);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    strike = '0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (odrop[d] !== 8'd0) begin
        errors++;
        $display("FAIL drop_clear d%0d got %0d req 0", d, odrop[d]);
      end
    end
    ready = 1'b1;
    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || opend[d] !== 4'b0 || odrop[d] !== 8'd0) begin
        errors++;
        $display("FAIL drop_drain d%0d got v%b p%b dr%0d req 0 0 0",
                 d, ov[d], opend[d], odrop[d]);
      end
    end
  endtask

  task automatic test_refractory();
    int cnt[2];
    cnt = '{0, 0};
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      strike = (c == 0 || c == 5 || c == 10) ? 4'b1000 : 4'b0000;
      zone_in = 12'(c % 8) << 9;
      tick();
      for (int d = 0; d < 2; d++)
        if (ov[d] === 1'b1) cnt[d]++;
      if (c == 9) begin
        checks++;
        if (cnt[0] !== 1 || odrop[0] !== 8'd0) begin
          errors++;
          $display("FAIL refr_window got ev%0d dr%0d req ev1 dr0",
                   cnt[0], odrop[0]);
        end
      end
    end
    checks++;
    if (cnt[0] !== 2 || odrop[0] !== 8'd0) begin
      errors++;
      $display("FAIL refr_expire got ev%0d dr%0d req ev2 dr0",
               cnt[0], odrop[0]);
    end
    checks++;
    if (cnt[1] !== 3) begin
      errors++;
      $display("FAIL refr_none got ev%0d req ev3", cnt[1]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready = 1'b0;
    strike = 4'b0001;
    zone_in = 12'd3;
    tick();
    strike = 4'b0110;
    zone_in = 12'o0120;
    tick();
    strike = '0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ov[d] !== 1'b1 || opend[d] !== 4'b0110) begin
        errors++;
        $display("FAIL arst_pre d%0d got v%b p%b req v1 p0110",
                 d, ov[d], opend[d]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({ov[d], och[d], ozn[d], opend[d], odrop[d]} !== '0) begin
        errors++;
        $display("FAIL arst_now d%0d got v%b c%0d z%0d p%b dr%0d req 0",
                 d, ov[d], och[d], ozn[d], opend[d], odrop[d]);
      end
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ov[d] !== 1'b0 || opend[d] !== 4'b0) begin
          errors++;
          $display("FAIL arst_quiet d%0d cyc%0d got v%b p%b req 0",
                   d, c, ov[d], opend[d]);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 4; k++)
        strike[k] = ($urandom_range(0, 3) == 0);
      zone_in = 12'($urandom);
      enable  = ($urandom_range(0, 9) != 0);
      ready   = (i < 400) ? ($urandom_range(0, 3) == 0)
                          : ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 59) == 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ov[d] !== 1'(m_v[d]) || och[d] !== 2'(m_ch[d]) ||
            ozn[d] !== 3'(m_zn[d]) || opend[d] !== m_pend[d] ||
            odrop[d] !== 8'(m_drop[d])) begin
          errors++;
          $display("FAIL random d%0d i%0d got v%b c%0d z%0d p%b dr%0d req v%0d c%0d z%0d p%b dr%0d",
                   d, i, ov[d], och[d], ozn[d], opend[d], odrop[d],
                   m_v[d], m_ch[d], m_zn[d], m_pend[d], m_drop[d]);
        end
      end
    end
    strike = '0;
    clr = 1'b0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_drops();
    test_refractory();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
